tdm_mux_8x1: RTL and testbench

TDM_MUX_8X1 -- requirements
Module: tdm_mux_8x1

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arb8.sv | 27 ++
 rtl/tdm_mux_8x1.sv | 83 ++++++++
 tb/tb_tdm_mux_8x1.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and state type for the 8:1 TDM serializer.
package mux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb8.sv
// Circular priority search: first set request at or after ptr, wrapping 7 -> 0.
module rr_arb8
    import mux_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the nearest request to ptr is written last and wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_8x1.sv
// Round-robin 8:1 serializer with a one-word output register tagged by source index.
// Optional even-parity output out_par when TDM_MUX_PARITY_EN is defined.
//
// state | meaning
// EMPTY | output register holds nothing, out_valid=0
// FULL  | output register holds a word, out_valid=1
module tdm_mux_8x1
    import mux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
`ifdef TDM_MUX_PARITY_EN
    output logic             out_par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt_idx;
    logic             any;
    logic             load_ok;
    logic             load;

    rr_arb8 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        in_ready  = '0;
        load_ok   = (state == EMPTY) || out_ready;
        // rst gating keeps in_ready low during the whole reset pulse, not just after the edge.
        if (!rst && load_ok && any) begin
            load              = 1'b1;
            in_ready[gnt_idx] = 1'b1;
            state_nxt         = FULL;
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= in_data[gnt_idx*W +: W];
                out_sel  <= gnt_idx;
                ptr      <= gnt_idx + SEL_W'(1);
            end
        end
    end

`ifdef TDM_MUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (load) begin
            out_par <= ^in_data[gnt_idx*W +: W];
        end
    end
`endif

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Scoreboard bench for tdm_mux_8x1: reference model predicts grants, monitor checks the output stream.
module tb_tdm_mux_8x1;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [7:0]     in_valid = '0;
    logic [8*W-1:0] in_data = '0;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
`ifdef TDM_MUX_PARITY_EN
    logic           out_par;
`endif

    tdm_mux_8x1 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef TDM_MUX_PARITY_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } word_t;

    word_t      sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_ptr = 0;
    bit         m_full = 0;
    logic [7:0] lb_vec = '0;

    function automatic void check(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle of stimulus; the model decides grant and output-register occupancy.
    task automatic step(input logic [7:0] v, input logic [8*W-1:0] d, input logic r);
        int    g;
        bit    found;
        bit    ld;
        word_t w;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        check("out_valid", out_valid, m_full);
        found = 0;
        g = 0;
        for (int i = 0; i < 8; i++) begin
            if (!found && v[(m_ptr + i) % 8]) begin
                g = (m_ptr + i) % 8;
                found = 1;
            end
        end
        ld = found && (!m_full || r);
        check("in_ready", in_ready, ld ? (64'd1 << g) : 64'd0);
        if (ld) begin
            w.sel  = 3'(g);
            w.data = d[g*W +: W];
            sb_q.push_back(w);
            m_ptr  = (g + 1) % 8;
            m_full = 1;
        end else if (m_full && r) begin
            m_full = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid = 8'hFF;
        in_data  = '1;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_data", out_data, 0);
        sb_q.delete();
        m_ptr  = 0;
        m_full = 0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = '0;
    endtask

    function automatic logic [8*W-1:0] rand_data();
        logic [8*W-1:0] d;
        for (int i = 0; i < 8*W; i += 32) d[i +: 32] = $urandom;
        return d;
    endfunction

    // Monitor: the held word must match the scoreboard head every valid cycle.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("out_sel", out_sel, sb_q[0].sel);
                check("out_data", out_data, sb_q[0].data);
`ifdef TDM_MUX_PARITY_EN
                check("out_par", out_par, ^sb_q[0].data);
`endif
                if (out_ready) begin
                    lb_vec[out_sel] = out_data[0];
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [8*W-1:0] d;
        logic [7:0]     pat;

        do_reset();

        // single request on channel 5, then FF must grant 6 (ptr advanced to 6)
        d = '0;
        d[5*W +: W] = W'(1);
        step(8'h20, d, 1'b1);
        step(8'hFF, rand_data(), 1'b1);
        step(8'h00, '0, 1'b1);
        step(8'h00, '0, 1'b1);

        // fairness: 0..7,0 back to back
        do_reset();
        for (int i = 0; i < 9; i++) step(8'hFF, rand_data(), 1'b1);
        step(8'h00, '0, 1'b1);

        // wrap-around: ptr to 7, then 7, 0, and ptr ends at 1
        do_reset();
        step(8'h40, rand_data(), 1'b1);
        step(8'h81, rand_data(), 1'b1);
        step(8'h81, rand_data(), 1'b1);
        step(8'h03, rand_data(), 1'b1);
        step(8'h00, '0, 1'b1);

        // backpressure: hold channel 2 word, then load channel 3 on release
        do_reset();
        d = rand_data();
        step(8'h04, d, 1'b1);
        repeat (4) step(8'h0C, d, 1'b0);
        step(8'h0C, d, 1'b1);
        step(8'h00, '0, 1'b1);

        // reset while FULL with out_sel=4; next search restarts at 0
        do_reset();
        step(8'h10, rand_data(), 1'b0);
        step(8'h00, '0, 1'b0);
        do_reset();
        step(8'h30, rand_data(), 1'b1);
        step(8'h00, '0, 1'b1);

        // loopback through a demux model: bit k of the pattern lands only on output k
        for (int k = 0; k < 8; k++) begin
            do_reset();
            lb_vec = '0;
            pat = 8'(1 << k);
            d = '0;
            for (int c = 0; c < 8; c++) d[c*W] = pat[c];
            repeat (8) step(8'hFF, d, 1'b1);
            step(8'h00, '0, 1'b1);
            step(8'h00, '0, 1'b1);
            check("loopback", lb_vec, pat);
        end

        // random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 8'($urandom);
            step(v, rand_data(), 1'($urandom_range(0, 3) != 0));
        end
        repeat (3) step(8'h00, '0, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
